// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, almost-full/almost-empty flags and standard or FWFT read
// Parameters: WIDTH data bits, DEPTH entries (power of 2, >= 2), AF_THRESH / AE_THRESH flag thresholds, FWFT read mode
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   wren, wrdata         write request and data; full, almost_full report write-side state
//   rden                 read request (standard) or pop (FWFT)
//   rddata, rdvalid      read word and its valid flag; empty, almost_empty report read-side state
//   count                words held, 0..DEPTH (includes the FWFT output register word)
// Optional: define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 1024,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wren,
    input  logic [WIDTH-1:0]         wrdata,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rden,
    output logic [WIDTH-1:0]         rddata,
    output logic                     rdvalid,
    output logic                     empty,
    output logic                     almost_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output logic                     overflow,
    output logic                     underflow,
`endif
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);
    localparam logic [AW:0] DEP = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AFT = (AW + 1)'(AF_THRESH);
    localparam logic [AW:0] AET = (AW + 1)'(AE_THRESH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo: AF_THRESH must be within 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo: AE_THRESH must be within 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("sync_fifo: FWFT must be 0 or 1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrptr, rdptr;
    logic             wr_ok, rd_ok, ld;

    // ld moves the word at rdptr into the output register. In FWFT mode the
    // output register refills whenever it is free or being popped and storage
    // (wrptr != rdptr) holds a word; a word written this edge is not yet visible.
    always_comb begin
        full         = count == DEP;
        empty        = (FWFT != 0) ? !rdvalid : count == '0;
        almost_full  = count >= AFT;
        almost_empty = count <= AET;
        wr_ok        = wren && !full;
        rd_ok        = rden && !empty;
        ld           = (FWFT != 0) ? (wrptr != rdptr) && (!rdvalid || rd_ok) : rd_ok;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wrptr[AW-1:0]] <= wrdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrptr   <= '0;
            rdptr   <= '0;
            count   <= '0;
            rdvalid <= 1'b0;
            rddata  <= '0;
        end else begin
            if (wr_ok) wrptr <= wrptr + ONE;
            if (ld) begin
                rdptr  <= rdptr + ONE;
                rddata <= mem[rdptr[AW-1:0]];
            end
            count   <= count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
            // standard: one-cycle pulse per read; FWFT: head stays valid until popped
            rdvalid <= ld || ((FWFT != 0) && rdvalid && !rd_ok);
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wren && full) overflow <= 1'b1;
            if (rden && empty) underflow <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized and directed checks of standard and FWFT sync_fifo against a queue model
module tb_sync_fifo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wren, rden;
    logic [15:0] wrdata;
    logic        s_full, s_af, s_empty, s_ae, s_rdvalid;
    logic        f_full, f_af, f_empty, f_ae, f_rdvalid;
    logic [15:0] s_rddata, f_rddata;
    logic [3:0]  s_count, f_count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic        s_ovf, s_unf, f_ovf, f_unf;
    bit          m_s_ovf, m_s_unf, m_f_ovf, m_f_unf;
`endif

    typedef struct {
        logic [15:0] d;
        int          t;
    } ent_t;

    logic [15:0] sq[$];
    ent_t        fq[$];
    logic [15:0] s_rd;
    bit          s_v;
    int          ecnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .wren(wren), .wrdata(wrdata), .full(s_full),
        .almost_full(s_af), .rden(rden), .rddata(s_rddata), .rdvalid(s_rdvalid),
        .empty(s_empty), .almost_empty(s_ae),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .overflow(s_ovf), .underflow(s_unf),
`endif
        .count(s_count)
    );

    sync_fifo #(.WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wren(wren), .wrdata(wrdata), .full(f_full),
        .almost_full(f_af), .rden(rden), .rddata(f_rddata), .rdvalid(f_rdvalid),
        .empty(f_empty), .almost_empty(f_ae),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .overflow(f_ovf), .underflow(f_unf),
`endif
        .count(f_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A FWFT head word is visible only from the edge after the one that wrote it.
    function automatic bit f_vis();
        return fq.size() > 0 && fq[0].t + 1 < ecnt;
    endfunction

    task automatic chk_all();
        int n = sq.size();
        int m = fq.size();
        bit v = f_vis();
        check("s_count", s_count, n);
        check("s_full", s_full, n == 8);
        check("s_empty", s_empty, n == 0);
        check("s_af", s_af, n >= 6);
        check("s_ae", s_ae, n <= 2);
        check("s_rdvalid", s_rdvalid, s_v);
        check("s_rddata", s_rddata, s_rd);
        check("f_count", f_count, m);
        check("f_full", f_full, m == 8);
        check("f_af", f_af, m >= 6);
        check("f_ae", f_ae, m <= 2);
        check("f_rdvalid", f_rdvalid, v);
        check("f_empty", f_empty, !v);
        if (v) check("f_rddata", f_rddata, fq[0].d);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("s_ovf", s_ovf, m_s_ovf);
        check("s_unf", s_unf, m_s_unf);
        check("f_ovf", f_ovf, m_f_ovf);
        check("f_unf", f_unf, m_f_unf);
`endif
    endtask

    task automatic step(input logic w, input logic [15:0] d, input logic r);
        bit s_wok, s_rok, f_wok, f_rok;
        wren   = w;
        wrdata = d;
        rden   = r;
        s_wok  = w && sq.size() < 8;
        s_rok  = r && sq.size() > 0;
        f_wok  = w && fq.size() < 8;
        f_rok  = r && f_vis();
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        m_s_ovf |= w && sq.size() == 8;
        m_s_unf |= r && sq.size() == 0;
        m_f_ovf |= w && fq.size() == 8;
        m_f_unf |= r && !f_vis();
`endif
        @(posedge clk);
        if (s_rok) s_rd = sq.pop_front();
        if (s_wok) sq.push_back(d);
        s_v = s_rok;
        if (f_rok) void'(fq.pop_front());
        if (f_wok) fq.push_back('{d, ecnt});
        ecnt++;
        #1;
        chk_all();
    endtask

    task automatic clear_model();
        sq.delete();
        fq.delete();
        s_rd = '0;
        s_v  = 1'b0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        m_s_ovf = 0; m_s_unf = 0; m_f_ovf = 0; m_f_unf = 0;
`endif
    endtask

    initial begin
        rst_n = 1'b0; wren = 1'b0; rden = 1'b0; wrdata = '0;
        clear_model();
        #12;
        chk_all();
        check("f_rddata_rst", f_rddata, 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) step(1'b1, 16'(i), 1'b0);
        check("s_count_full9", s_count, 8);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 16'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 16'($urandom), 1'b1);
        check("s_count_hold4", s_count, 4);
        for (int i = 0; i < 4; i++) step(1'b1, 16'($urandom), 1'b0);
        step(1'b1, 16'h1234, 1'b1);
        check("s_count_wr_full", s_count, 7);
        check("f_count_wr_full", f_count, 7);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 16'h5678, 1'b1);
        check("s_count_rd_empty", s_count, 1);
        check("f_count_rd_empty", f_count, 1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 16'hBEEF, 1'b0);
        check("f_beef_n", f_rdvalid, 0);
        step(1'b0, '0, 1'b0);
        check("f_beef_valid", f_rdvalid, 1);
        check("f_beef_data", f_rddata, 16'hBEEF);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 32; i++) step(1'b1, 16'(16'h100 + i), 1'b1);
        check("f_stream_valid", f_rdvalid, 1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 45);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        chk_all();
        check("f_rddata_async_rst", f_rddata, 0);
        rst_n = 1'b1;
        step(1'b1, 16'h00AA, 1'b0);
        step(1'b1, 16'h00BB, 1'b0);
        step(1'b0, '0, 1'b0);
        check("f_first_after_rst", f_rddata, 16'h00AA);
        step(1'b0, '0, 1'b1);
        check("s_first_after_rst", s_rddata, 16'h00AA);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
